// File: rtl/i2c_config_seq.sv
// Table-driven I2C register-write sequencer: walks a configuration table, issues one
// controller transfer per entry with NACK/timeout retry, and supports 0xFF delay entries.
module i2c_config_seq #(
    parameter int CLK_FREQ   = 50000000,
    parameter int I2C_FREQ   = 20000,
    parameter int LUT_SIZE   = 50,
    parameter int IDX_W      = 6,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 1024,
    parameter int AUTO_START = 1
) (
    input  logic             CLOCK_50,
    input  logic             iRST_N,
    input  logic             iSTART,
    output logic [IDX_W-1:0] oTBL_IDX,
    input  logic [23:0]      iTBL_DATA,
    output logic [23:0]      oI2C_DATA,
    output logic             oI2C_GO,
    input  logic             iI2C_END,
    input  logic             iI2C_ACK,
    output logic             oCTRL_TICK,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR,
    output logic [IDX_W-1:0] oERR_IDX
);

    // state      | meaning
    // IDLE       | waiting for start (or auto-start after reset)
    // FETCH      | latch table word, decide transfer vs delay
    // ISSUE      | present word to controller, raise GO
    // WAIT_END   | GO high until END or timeout
    // WAIT_LOW   | wait for END release, then advance / retry / fail
    // DELAY      | count down {sub,data} ticks
    // NEXT       | advance index or finish
    // DONE       | all entries written
    // FAIL       | retries exhausted on oERR_IDX
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_ISSUE    = 4'd2;
    localparam logic [3:0] S_WAIT_END = 4'd3;
    localparam logic [3:0] S_WAIT_LOW = 4'd4;
    localparam logic [3:0] S_DELAY    = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;

    localparam int TDIV = CLK_FREQ / (2 * I2C_FREQ);
    localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam int TOW  = $clog2(TIMEOUT + 1);
    localparam int RTW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]    TICK_LAST = TW'(TDIV - 1);
    localparam logic [TOW-1:0]   TMO_LAST  = TOW'(TIMEOUT - 1);
    localparam logic [RTW-1:0]   RETRY_MAX = RTW'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LUT_SIZE - 1);

    logic [TW-1:0]    r_tick_cnt;
    logic [3:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [RTW-1:0]   r_retry;
    logic [TOW-1:0]   r_tmo;
    logic [15:0]      r_delay;
    logic [23:0]      r_word;
    logic [23:0]      r_i2c_data;
    logic             r_go;
    logic             r_ack_ok;
    logic             r_done;
    logic             r_err;
    logic [IDX_W-1:0] r_err_idx;
    logic             r_auto;
    logic             w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Start is honoured on any cycle and in any state; everything else is tick-paced.
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_retry    <= '0;
            r_tmo      <= '0;
            r_delay    <= '0;
            r_word     <= '0;
            r_i2c_data <= '0;
            r_go       <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
            r_auto     <= (AUTO_START != 0);
        end else begin
            r_auto <= 1'b0;
            if (iSTART || r_auto) begin
                r_state   <= S_FETCH;
                r_idx     <= '0;
                r_retry   <= '0;
                r_tmo     <= '0;
                r_go      <= 1'b0;
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_err_idx <= '0;
            end else if (w_tick) begin
                case (r_state)
                    S_FETCH: begin
                        r_word <= iTBL_DATA;
                        if (iTBL_DATA[23:16] == 8'hFF) begin
                            r_delay <= iTBL_DATA[15:0];
                            r_state <= S_DELAY;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // GO may only rise once the controller has released END.
                        if (!iI2C_END) begin
                            r_i2c_data <= r_word;
                            r_go       <= 1'b1;
                            r_tmo      <= '0;
                            r_state    <= S_WAIT_END;
                        end
                    end
                    S_WAIT_END: begin
                        if (iI2C_END) begin
                            r_go     <= 1'b0;
                            r_ack_ok <= ~iI2C_ACK;
                            r_state  <= S_WAIT_LOW;
                        end else if (r_tmo == TMO_LAST) begin
                            r_go     <= 1'b0;
                            r_ack_ok <= 1'b0;
                            r_state  <= S_WAIT_LOW;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    S_WAIT_LOW: begin
                        if (!iI2C_END) begin
                            if (r_ack_ok) begin
                                r_state <= S_NEXT;
                            end else if (r_retry < RETRY_MAX) begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_ISSUE;
                            end else begin
                                r_err     <= 1'b1;
                                r_err_idx <= r_idx;
                                r_state   <= S_FAIL;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (r_delay == 16'd0) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_delay <= r_delay - 16'd1;
                        end
                    end
                    S_NEXT: begin
                        r_retry <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign oTBL_IDX   = r_idx;
    assign oI2C_DATA  = r_i2c_data;
    assign oI2C_GO    = r_go;
    assign oCTRL_TICK = w_tick;
    assign oBUSY      = (r_state >= S_FETCH) && (r_state <= S_NEXT);
    assign oDONE      = r_done;
    assign oERR       = r_err;
    assign oERR_IDX   = r_err_idx;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench for i2c_config_seq: a table of sequence scenarios plus hand-written
// sequences for timeout width, delay spacing, restart and asynchronous reset.
module tb_i2c_config_seq;

    localparam int TDIV = 5;

    logic        CLOCK_50 = 1'b0;
    logic        iRST_N   = 1'b0;
    logic        iSTART   = 1'b0;
    logic [5:0]  oTBL_IDX;
    logic [23:0] iTBL_DATA = '0;
    logic [23:0] oI2C_DATA;
    logic        oI2C_GO;
    logic        iI2C_END = 1'b0;
    logic        iI2C_ACK = 1'b0;
    logic        oCTRL_TICK;
    logic        oBUSY;
    logic        oDONE;
    logic        oERR;
    logic [5:0]  oERR_IDX;

    i2c_config_seq #(
        .CLK_FREQ(1000), .I2C_FREQ(100), .LUT_SIZE(4), .IDX_W(6),
        .MAX_RETRY(3), .TIMEOUT(16), .AUTO_START(1)
    ) dut (
        .CLOCK_50(CLOCK_50), .iRST_N(iRST_N), .iSTART(iSTART),
        .oTBL_IDX(oTBL_IDX), .iTBL_DATA(iTBL_DATA),
        .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
        .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK),
        .oCTRL_TICK(oCTRL_TICK), .oBUSY(oBUSY), .oDONE(oDONE),
        .oERR(oERR), .oERR_IDX(oERR_IDX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [0:3][23:0] tbl;
        int               nack_idx;
        int               nack_n;
        bit               no_end;
        int               exp_n;
        logic [0:7][23:0] exp_seq;
        bit               exp_done;
        bit               exp_err;
        int               exp_eidx;
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // scenario configuration, written by the stimulus process only
    logic [0:3][23:0] cur_tbl = '0;
    int nack_idx = 7;
    int nack_n   = 0;
    bit no_end   = 1'b0;
    int lat_cfg  = 3;
    int epoch    = 0;

    // controller model state, written by the model process only
    int          ms = 0;
    int          lat = 0;
    int          cur_e = 0;
    int          seen_epoch = 0;
    int          nack_cnt = 0;
    int          log_n = 0;
    logic [23:0] log_w[16];
    int          log_rise[16];
    int          log_dur[16];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Table ROM plus a simple I2C controller: END a few cycles after GO, held until GO drops.
    always @(negedge CLOCK_50) begin
        iTBL_DATA = cur_tbl[oTBL_IDX[1:0]];
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            log_n      = 0;
            nack_cnt   = 0;
        end
        if (!iRST_N) begin
            ms       = 0;
            iI2C_END = 1'b0;
            iI2C_ACK = 1'b0;
        end else begin
            case (ms)
                0: if (oI2C_GO) begin
                    if (log_n < 16) begin
                        log_w[log_n]    = oI2C_DATA;
                        log_rise[log_n] = cyc;
                    end
                    log_n = log_n + 1;
                    cur_e = int'(oTBL_IDX);
                    lat   = lat_cfg;
                    ms    = no_end ? 3 : 1;
                end
                1: if (!oI2C_GO) begin
                    if (log_n > 0 && log_n <= 16) log_dur[log_n-1] = cyc - log_rise[log_n-1];
                    ms = 0;
                end else if (lat <= 1) begin
                    iI2C_END = 1'b1;
                    if (cur_e == nack_idx && nack_cnt < nack_n) begin
                        iI2C_ACK = 1'b1;
                        nack_cnt = nack_cnt + 1;
                    end else begin
                        iI2C_ACK = 1'b0;
                    end
                    ms = 2;
                end else begin
                    lat = lat - 1;
                end
                default: if (!oI2C_GO) begin
                    if (log_n > 0 && log_n <= 16) log_dur[log_n-1] = cyc - log_rise[log_n-1];
                    iI2C_END = 1'b0;
                    ms       = 0;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic setup_vec(input int k);
        cur_tbl  = vecs[k].tbl;
        nack_idx = vecs[k].nack_idx;
        nack_n   = vecs[k].nack_n;
        no_end   = vecs[k].no_end;
        lat_cfg  = 3;
        epoch    = epoch + 1;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50);
        iSTART = 1'b1;
        @(negedge CLOCK_50);
        iSTART = 1'b0;
    endtask

    task automatic check_vec(input int k);
        int guard = 0;
        while (!(oDONE || oERR) && guard < 20000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (guard >= 20000) begin
            n_cmp++;
            n_err++;
            $display("FAIL vec%0d_wait: no done/err after %0d cycles", k, guard);
        end
        check($sformatf("vec%0d_xfers", k), 64'(log_n), 64'(vecs[k].exp_n));
        for (int i = 0; i < vecs[k].exp_n && i < log_n && i < 8; i++)
            check($sformatf("vec%0d_word%0d", k, i), 64'(log_w[i]), 64'(vecs[k].exp_seq[i]));
        check($sformatf("vec%0d_done", k), 64'(oDONE), 64'(vecs[k].exp_done));
        check($sformatf("vec%0d_err", k), 64'(oERR), 64'(vecs[k].exp_err));
        check($sformatf("vec%0d_busy", k), 64'(oBUSY), 64'd0);
        if (vecs[k].exp_err)
            check($sformatf("vec%0d_erridx", k), 64'(oERR_IDX), 64'(vecs[k].exp_eidx));
    endtask

    initial begin
        int gap5;
        int gap0;
        int guard;

        // all ACK
        vecs[0].tbl = {24'h340018, 24'h340218, 24'h401500, 24'h401741};
        vecs[0].nack_idx = 7; vecs[0].nack_n = 0; vecs[0].no_end = 0; vecs[0].exp_n = 4;
        vecs[0].exp_seq = {24'h340018, 24'h340218, 24'h401500, 24'h401741, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[0].exp_done = 1; vecs[0].exp_err = 0; vecs[0].exp_eidx = 0;
        // entry 2 always NACKs: 1 + 3 retries, entry 3 never sent
        vecs[1] = vecs[0];
        vecs[1].nack_idx = 2; vecs[1].nack_n = 1000; vecs[1].exp_n = 6;
        vecs[1].exp_seq = {24'h340018, 24'h340218, 24'h401500, 24'h401500, 24'h401500, 24'h401500, 24'h0, 24'h0};
        vecs[1].exp_done = 0; vecs[1].exp_err = 1; vecs[1].exp_eidx = 2;
        // entry 1 NACKs once
        vecs[2] = vecs[0];
        vecs[2].nack_idx = 1; vecs[2].nack_n = 1; vecs[2].exp_n = 5;
        vecs[2].exp_seq = {24'h340018, 24'h340218, 24'h340218, 24'h401500, 24'h401741, 24'h0, 24'h0, 24'h0};
        // END never comes: entry 0 times out four times
        vecs[3] = vecs[0];
        vecs[3].no_end = 1; vecs[3].exp_n = 4;
        vecs[3].exp_seq = {24'h340018, 24'h340018, 24'h340018, 24'h340018, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[3].exp_done = 0; vecs[3].exp_err = 1; vecs[3].exp_eidx = 0;
        // delay entries produce no transfer
        vecs[4] = vecs[0];
        vecs[4].tbl = {24'h340018, 24'hFF0005, 24'h401500, 24'h401741};
        vecs[4].exp_n = 3;
        vecs[4].exp_seq = {24'h340018, 24'h401500, 24'h401741, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        vecs[5] = vecs[4];
        vecs[5].tbl = {24'h340018, 24'hFF0000, 24'h401500, 24'h401741};

        setup_vec(0);
        #23;
        check("reset_outputs",
              64'({oTBL_IDX, oI2C_DATA, oI2C_GO, oCTRL_TICK, oBUSY, oDONE, oERR, oERR_IDX}), 64'd0);

        // auto-start after reset release runs vector 0
        @(negedge CLOCK_50);
        iRST_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("autostart_busy", 64'(oBUSY), 64'd1);
        check_vec(0);

        for (int k = 1; k < 6; k++) begin
            setup_vec(k);
            pulse_start();
            check($sformatf("vec%0d_start_clears", k), 64'({oDONE, oERR, oTBL_IDX}), 64'd0);
            check_vec(k);
            if (k == 3) check("timeout_go_width", 64'(log_dur[0]), 64'(16 * TDIV));
            if (k == 4) gap5 = log_rise[1] - log_rise[0];
            if (k == 5) gap0 = log_rise[1] - log_rise[0];
        end
        check("delay5_vs_delay0_cycles", 64'(gap5 - gap0), 64'(5 * TDIV));

        // restart while entry 3 is in flight
        setup_vec(0);
        lat_cfg = 40;
        pulse_start();
        guard = 0;
        while (!(oI2C_GO && oTBL_IDX == 6'd3) && guard < 5000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check("restart_reached_entry3", 64'(guard < 5000), 64'd1);
        repeat (10) @(negedge CLOCK_50);
        epoch = epoch + 1;
        pulse_start();
        check("restart_go_dropped", 64'(oI2C_GO), 64'd0);
        check("restart_idx0_busy", 64'({oTBL_IDX, oBUSY}), 64'd1);
        check_vec(0);

        // asynchronous reset in the middle of a transfer, then auto-start again
        setup_vec(0);
        lat_cfg = 40;
        pulse_start();
        guard = 0;
        while (!oI2C_GO && guard < 5000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check("rst_reached_go", 64'(oI2C_GO), 64'd1);
        @(posedge CLOCK_50);
        #2;
        iRST_N = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({oTBL_IDX, oI2C_DATA, oI2C_GO, oCTRL_TICK, oBUSY, oDONE, oERR, oERR_IDX}), 64'd0);
        epoch = epoch + 1;
        repeat (3) @(negedge CLOCK_50);
        iRST_N = 1'b1;
        check_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_config_seq.md
I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 20000, I2C control rate in Hz; tick period TDIV = CLK_FREQ/(2*I2C_FREQ) cycles.
REQ-003 SHALL have parameter LUT_SIZE, default 50, number of table entries.
REQ-004 SHALL have parameter IDX_W, default 6, table index width; LUT_SIZE <= 2^IDX_W.
REQ-005 SHALL have parameter MAX_RETRY, default 3, reissues allowed per entry after NACK or timeout.
REQ-006 SHALL have parameter TIMEOUT, default 1024, ticks allowed between GO rise and END.
REQ-007 SHALL have parameter AUTO_START, default 1; 1 = sequence starts after reset.
REQ-008 CLOCK_50  in  1  system clock; the only clock.
REQ-009 iRST_N  in  1  reset, asynchronous, active-low.
REQ-010 iSTART  in  1  one-cycle pulse; (re)starts the sequence from index 0.
REQ-011 oTBL_IDX  out  IDX_W  table read address.
REQ-012 iTBL_DATA  in  24  table word {slave[7:0], sub[7:0], data[7:0]}, valid 1 cycle after oTBL_IDX changes.
REQ-013 oI2C_DATA  out  24  word to I2C controller.
REQ-014 oI2C_GO  out  1  transfer request.
REQ-015 iI2C_END  in  1  transfer complete, level.
REQ-016 iI2C_ACK  in  1  sampled with END; 0 = acknowledged, 1 = NACK.
REQ-017 oCTRL_TICK  out  1  one-cycle enable every TDIV cycles, drives controller and FSM pacing.
REQ-018 oBUSY  out  1  sequence in progress.
REQ-019 oDONE  out  1  all entries written successfully; held until next start.
REQ-020 oERR  out  1  sequence aborted; held until next start.
REQ-021 oERR_IDX  out  IDX_W  index of failing entry.

Function
REQ-022 Tick counter SHALL count 0..TDIV-1 free-running, pulsing oCTRL_TICK on count TDIV-1; all FSM transitions except IDLE->FETCH SHALL occur only on tick cycles.
REQ-023 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT_END, WAIT_LOW, DELAY, NEXT, DONE, FAIL.
REQ-024 IDLE->FETCH on iSTART (any state, including mid-transfer) or first cycle after reset if AUTO_START=1; on start: index, retry count cleared, oDONE/oERR cleared, oI2C_GO=0.
REQ-025 FETCH: latch iTBL_DATA; slave==8'hFF -> DELAY loading {sub,data} as tick count; else ISSUE.
REQ-026 ISSUE: oI2C_DATA=latched word, oI2C_GO=1, timeout counter cleared -> WAIT_END.
REQ-027 WAIT_END: GO held high; on END=1 drop GO -> WAIT_LOW with result=ACK; timeout counter reaching TIMEOUT drops GO -> WAIT_LOW with result=NACK.
REQ-028 WAIT_LOW: wait END=0; then result ACK -> NEXT; result NACK and retry<MAX_RETRY -> retry+1, ISSUE (same index); otherwise FAIL.
REQ-029 DELAY: decrement per tick; count 0 -> NEXT immediately (zero delay legal).
REQ-030 NEXT: retry cleared; index==LUT_SIZE-1 -> DONE, else index+1 -> FETCH.
REQ-031 DONE: oDONE=1, oBUSY=0, stay until iSTART.
REQ-032 FAIL: oERR=1, oERR_IDX=index, oBUSY=0, stay until iSTART.
REQ-033 oBUSY SHALL be 1 in FETCH..NEXT inclusive.
REQ-034 oI2C_GO SHALL never re-rise while iI2C_END=1.

Reset
REQ-035 On iRST_N=0 asynchronously: state IDLE, tick/index/retry/timeout/delay counters 0, oI2C_GO=0, oI2C_DATA=0, oBUSY=0, oDONE=0, oERR=0, oERR_IDX=0, oCTRL_TICK=0.
REQ-036 Reset mid-transfer SHALL drop oI2C_GO within the reset assertion, with no tick required.

Verification
REQ-037 LUT_SIZE=4, all ACK, table {34_0018,34_0218,40_1500,40_1741} -> four GO pulses with those words in order, oDONE=1, oERR=0.
REQ-038 Entry 2 NACKs always, MAX_RETRY=3 -> 4 transfers of entry 2, oERR=1, oERR_IDX=2, no transfer of entry 3.
REQ-039 Entry 1 NACKs once then ACKs -> 2 transfers of entry 1, sequence completes, oDONE=1.
REQ-040 Entry FF_0005 -> no GO, 5 ticks idle between neighbours; entry FF_0000 -> 0 ticks.
REQ-041 END never asserted, TIMEOUT=16 -> GO drops after 16 ticks, retries, then oERR=1.
REQ-042 iSTART pulse during WAIT_END of entry 3 -> GO drops, sequence restarts at index 0; iRST_N low mid-transfer -> all outputs at reset values.
